// File: rtl/fir_out_packer.sv
// Packs narrow FIR output samples into wide words for the TCDM streamer.
// Samples fill lanes from the LSB upward. A full word is emitted as soon as its
// last lane arrives. A flush pulse emits any partial word with zeroed unfilled
// lanes and a strobe that covers only the filled lanes.
module fir_out_packer #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned OUT_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [SAMPLE_W-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [OUT_W-1:0]     out_data_o,
    output logic [OUT_W/8-1:0]   out_strb_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 flush_done_o,
    output logic [15:0]          cnt_o
);

    localparam int unsigned Lanes     = OUT_W / SAMPLE_W;
    localparam int unsigned LaneW     = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned LaneBytes = SAMPLE_W / 8;
    localparam int unsigned StrbW     = OUT_W / 8;
    localparam logic [LaneW-1:0] LastLane = LaneW'(Lanes - 1);

    typedef enum logic [1:0] {
        StFill,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [LaneW-1:0]  lane_q, lane_d;
    logic [OUT_W-1:0]  pack_q, pack_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [StrbW-1:0]  out_strb_q, out_strb_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              in_fire;
    logic              out_fire;
    logic              out_free;
    logic [OUT_W-1:0]  merged;
    logic [StrbW-1:0]  partial_strb;

    // The last lane may only be accepted when the output register can take the word.
    always_comb begin
        in_ready_o = (state_q != StFlush) &&
                     ((lane_q != LastLane) || !out_valid_q || out_ready_i);
        in_fire    = in_valid_i && in_ready_o;
        out_fire   = out_valid_q && out_ready_i;
        out_free   = !out_valid_q || out_ready_i;
    end

    // Pack register with the incoming sample dropped into the current lane, and
    // the strobe covering only the lanes filled so far.
    always_comb begin
        merged = pack_q;
        merged[lane_q*SAMPLE_W +: SAMPLE_W] = in_data_i;
        partial_strb = '0;
        for (int i = 0; i < Lanes; i++) begin
            if (LaneW'(i) < lane_q) begin
                partial_strb[i*LaneBytes +: LaneBytes] = '1;
            end
        end
    end

    // Next-state logic for the packer datapath and flush FSM.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        cnt_d       = cnt_q;

        if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (in_fire) begin
            if (lane_q == LastLane) begin
                out_data_d  = merged;
                out_strb_d  = '1;
                out_valid_d = 1'b1;
                pack_d      = '0;
                lane_d      = '0;
            end else begin
                pack_d = merged;
                lane_d = lane_q + 1'b1;
            end
        end

        unique case (state_q)
            StFill: begin
                // A same-cycle input is packed first; if nothing is left over, the
                // flush completes without a FLUSH cycle.
                if (flush_i) begin
                    state_d = (lane_d == '0) ? StDone : StFlush;
                end
            end
            StFlush: begin
                if (lane_q == '0) begin
                    state_d = StDone;
                end else if (out_free) begin
                    out_data_d  = pack_q;
                    out_strb_d  = partial_strb;
                    out_valid_d = 1'b1;
                    pack_d      = '0;
                    lane_d      = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StFill;
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    // State registers; clear_i behaves exactly like reset and overrides transfers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q     <= StFill;
            lane_q      <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_strb_o   = out_strb_q;
    assign out_valid_o  = out_valid_q;
    assign flush_done_o = (state_q == StDone);
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_fir_out_packer.sv
// Directed bench for fir_out_packer (SAMPLE_W=16, OUT_W=32). Expected output
// words are queued when stimulus is driven and checked when the DUT emits them.
module tb_fir_out_packer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic        out_valid;
    logic        out_ready;
    logic        flush_done;
    logic [15:0] cnt;

    int tests  = 0;
    int failed = 0;
    int fd_cnt = 0;
    logic [35:0] sb[$];

    fir_out_packer #(
        .SAMPLE_W(16),
        .OUT_W   (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .flush_done_o(flush_done),
        .cnt_o       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and wait (bounded) until it is accepted.
    task automatic send(input logic [15:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (flush_done) fd_cnt++;
        if (rst_n && !clear && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", out_data, 32'hDEAD_BEEF);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                chk("sb_data", out_data, e[35:4]);
                chk("sb_strb", 32'(out_strb), 32'(e[3:0]));
            end
        end
    end

    initial begin
        int fd0;
        rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_strb", 32'(out_strb), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Full word, one-cycle latency
        sb.push_back({32'h2222_1111, 4'hF});
        send(16'h1111);
        send(16'h2222);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_data", out_data, 32'h2222_1111);
        step();
        chk("full_cnt", 32'(cnt), 32'd1);

        // Partial flush
        sb.push_back({32'h0000_ABCD, 4'h3});
        send(16'hABCD);
        fd0 = fd_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("pflush_pending_valid", 32'(out_valid), 32'd0);
        step();
        chk("pflush_valid", 32'(out_valid), 32'd1);
        chk("pflush_done", 32'(flush_done), 32'd1);
        chk("pflush_strb", 32'(out_strb), 32'h3);
        step();
        chk("pflush_done_once", 32'(fd_cnt - fd0), 32'd1);
        chk("pflush_lane", 32'(dut.lane_q), 32'd0);
        chk("pflush_cnt", 32'(cnt), 32'd2);

        // Back-to-back throughput
        sb.push_back({32'h0011_0010, 4'hF});
        sb.push_back({32'h0013_0012, 4'hF});
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h0010 + 16'(i);
            chk("tput_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("tput_cnt", 32'(cnt), 32'd4);

        // Backpressure
        out_ready = 1'b0;
        sb.push_back({32'h0002_0001, 4'hF});
        sb.push_back({32'h0004_0003, 4'hF});
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        chk("bp_ready_drop", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h0004;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold_data", out_data, 32'h0002_0001);
            chk("bp_hold_strb", 32'(out_strb), 32'hF);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_second_word", out_data, 32'h0004_0003);
        step();
        chk("bp_cnt", 32'(cnt), 32'd6);

        // Empty flush
        fd0 = fd_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("eflush_done", 32'(flush_done), 32'd1);
        chk("eflush_valid", 32'(out_valid), 32'd0);
        step();
        chk("eflush_done_drop", 32'(flush_done), 32'd0);
        chk("eflush_once", 32'(fd_cnt - fd0), 32'd1);
        chk("eflush_cnt", 32'(cnt), 32'd6);

        // Input in the same cycle as flush
        sb.push_back({32'h0000_5555, 4'h3});
        in_valid = 1'b1;
        in_data  = 16'h5555;
        flush    = 1'b1;
        chk("simul_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
        chk("simul_valid", 32'(out_valid), 32'd1);
        chk("simul_data", out_data, 32'h0000_5555);
        chk("simul_strb", 32'(out_strb), 32'h3);
        step();
        chk("simul_cnt", 32'(cnt), 32'd7);

        // Reset mid-word
        send(16'h7777);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rmid_valid", 32'(out_valid), 32'd0);
        chk("rmid_cnt", 32'(cnt), 32'd0);
        sb.push_back({32'h0002_0001, 4'hF});
        send(16'h0001);
        send(16'h0002);
        step();
        chk("rmid_after_cnt", 32'(cnt), 32'd1);

        // Clear wins over a coinciding word-completing input
        send(16'h0009);
        in_valid = 1'b1;
        in_data  = 16'h000C;
        clear    = 1'b1;
        step();
        in_valid = 1'b0;
        clear    = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);
        sb.push_back({32'h000B_000A, 4'hF});
        send(16'h000A);
        send(16'h000B);
        step();
        chk("clr_after_cnt", 32'(cnt), 32'd1);

        repeat (2) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
